// File: rtl/spc_cfg_pkg.sv
// spc_cfg_pkg: shared state type and default sizing for the configuration-chain sequencer
// Optional feature macro: SPC_CFG_READBACK_EN adds the CHECK state.
package spc_cfg_pkg;
   localparam int DEF_CFG_WIDTH = 32;
   localparam int DEF_CLK_DIV   = 4;
`ifdef SPC_CFG_READBACK_EN
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH, ST_CHECK} state_e;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_e;
`endif
endpackage

// File: rtl/spc_cfg_clkdiv.sv
// spc_cfg_clkdiv: Cfg_clk phase generator, CLK_DIV cycles low then CLK_DIV cycles high
// Ports: Clk/Resetn clock and async active-low reset; clr_i restarts at the first low cycle;
//        ph_o phase (1 = high); low_start_o first low cycle; rise_o last low cycle (Cfg_clk
//        rises at the following edge); high_end_o last high cycle; wrap_o last cycle of a phase.
module spc_cfg_clkdiv #(
   parameter int CLK_DIV = 4
) (
   input  logic Clk,
   input  logic Resetn,
   input  logic clr_i,
   output logic ph_o,
   output logic low_start_o,
   output logic rise_o,
   output logic high_end_o,
   output logic wrap_o
);
   localparam int CW = $clog2(CLK_DIV + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ph_q, ph_d;
   assign wrap_o = cnt_q == CW'(CLK_DIV - 1);
   always_comb begin
      cnt_d = (clr_i || wrap_o) ? '0 : cnt_q + 1'b1;
      ph_d  = clr_i ? 1'b0 : ph_q ^ wrap_o;
   end
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         cnt_q <= '0;
         ph_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ph_q  <= ph_d;
      end
   end
   assign ph_o        = ph_q;
   assign low_start_o = !ph_q && cnt_q == '0;
   assign rise_o      = !ph_q && wrap_o;
   assign high_end_o  = ph_q && wrap_o;
endmodule

// File: rtl/spc_cfg_sequencer.sv
// spc_cfg_sequencer: loads a word MSB-first into a serial configuration chain, then strobes Cfg_load
// Ports: Clk, Resetn (async active-low); Word/Word_valid/Word_ready request handshake;
//        Cfg_out/Cfg_clk/Cfg_load chain drive; Cfg_ret chain return; Busy, Done pulse, Err.
// Optional feature macro: SPC_CFG_READBACK_EN re-shifts the word after LATCH and compares Cfg_ret.
module spc_cfg_sequencer
   import spc_cfg_pkg::*;
#(
   parameter int CFG_WIDTH = DEF_CFG_WIDTH,
   parameter int CLK_DIV   = DEF_CLK_DIV
) (
   input  logic                 Clk,
   input  logic                 Resetn,
   input  logic [CFG_WIDTH-1:0] Word,
   input  logic                 Word_valid,
   output logic                 Word_ready,
   output logic                 Cfg_out,
   output logic                 Cfg_clk,
   output logic                 Cfg_load,
   input  logic                 Cfg_ret,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Err
);
   localparam int BW = $clog2(CFG_WIDTH);
   state_e               state_q, state_d;
   logic [CFG_WIDTH-1:0] sr_q, sr_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 ph, low_start, rise, high_end, wrap, shifting, last_bit, unused_sig;
   // divider restarts on every state change so each phase of each state starts aligned
   spc_cfg_clkdiv #(.CLK_DIV(CLK_DIV)) u_div (
      .Clk         (Clk),
      .Resetn      (Resetn),
      .clr_i       (state_q == ST_IDLE || state_d != state_q),
      .ph_o        (ph),
      .low_start_o (low_start),
      .rise_o      (rise),
      .high_end_o  (high_end),
      .wrap_o      (wrap)
   );
`ifdef SPC_CFG_READBACK_EN
   assign shifting = state_q == ST_SHIFT || state_q == ST_CHECK;
`else
   assign shifting = state_q == ST_SHIFT;
`endif
   assign last_bit = bit_q == BW'(CFG_WIDTH - 1);
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bit_d   = bit_q;
      Done    = 1'b0;
      case (state_q)
         ST_IDLE: if (Word_valid) begin
            sr_d    = Word;
            bit_d   = '0;
            state_d = ST_SHIFT;
         end
         ST_LATCH: if (wrap) begin
`ifdef SPC_CFG_READBACK_EN
            state_d = ST_CHECK;
`else
            state_d = ST_IDLE;
            Done    = 1'b1;
`endif
         end
         // SHIFT and CHECK: rotating rather than shifting leaves the original word in
         // place after a full pass, ready for the readback pass
         default: if (high_end) begin
            sr_d  = {sr_q[CFG_WIDTH-2:0], sr_q[CFG_WIDTH-1]};
            bit_d = last_bit ? '0 : bit_q + 1'b1;
            if (last_bit) begin
               state_d = (state_q == ST_SHIFT) ? ST_LATCH : ST_IDLE;
               Done    = state_q != ST_SHIFT;
            end
         end
      endcase
   end
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         bit_q   <= bit_d;
      end
   end
   assign Word_ready = state_q == ST_IDLE;
   assign Busy       = !Word_ready;
   assign Cfg_load   = state_q == ST_LATCH;
   assign Cfg_clk    = shifting && ph;
   assign Cfg_out    = shifting && sr_q[CFG_WIDTH-1];
`ifdef SPC_CFG_READBACK_EN
   logic err_q, err_d;
   // Cfg_ret is sampled at the edge where Cfg_clk rises, against the bit being presented
   assign err_d = (state_q == ST_IDLE && Word_valid) ? 1'b0 :
                  (state_q == ST_CHECK && rise && Cfg_ret != sr_q[CFG_WIDTH-1]) ? 1'b1 : err_q;
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) err_q <= 1'b0;
      else         err_q <= err_d;
   end
   assign Err        = err_q;
   assign unused_sig = low_start;
`else
   assign Err        = 1'b0;
   assign unused_sig = low_start ^ rise ^ Cfg_ret;
`endif
endmodule

// File: doc/spc_cfg_sequencer.md
SPC_CFG_SEQUENCER -- requirements
Module: spc_cfg_sequencer

Interface
REQ-001 Parameter CFG_WIDTH, default 32: number of bits in the serial configuration chain (legal range 2..256).
REQ-002 Parameter CLK_DIV, default 4: Clk cycles per half-period of Cfg_clk (legal range 1..255).
REQ-003 Clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 Resetn  input  1  asynchronous reset, active-low.
REQ-005 Word  input  CFG_WIDTH  configuration word to load; the MSB is shifted first.
REQ-006 Word_valid  input  1  requester has a word on Word.
REQ-007 Word_ready  output  1  the block accepts Word in this cycle.
REQ-008 Cfg_out  output  1  serial data to the chain input.
REQ-009 Cfg_clk  output  1  serial shift clock to the chain.
REQ-010 Cfg_load  output  1  parallel latch strobe to the chain.
REQ-011 Cfg_ret  input  1  serial data returned from the chain end; used only with SPC_CFG_READBACK_EN.
REQ-012 Busy  output  1  a sequence is in progress.
REQ-013 Done  output  1  one-cycle pulse when a sequence completes.
REQ-014 Err  output  1  readback mismatch flag; held at 0 without SPC_CFG_READBACK_EN.

Function
REQ-015 States: IDLE, SHIFT, LATCH and CHECK; CHECK exists only with SPC_CFG_READBACK_EN.
REQ-016 IDLE: Word_ready=1; when Word_valid=1, Word is captured into a shift register, Err is cleared, and the state becomes SHIFT in the next cycle.
REQ-017 Word_ready=0 in every state other than IDLE; Word_valid is ignored outside IDLE.
REQ-018 SHIFT bit period: Cfg_clk is low for CLK_DIV cycles and then high for CLK_DIV cycles, so one bit takes 2*CLK_DIV cycles.
REQ-019 Cfg_out changes only while Cfg_clk is low, at the first cycle of the low phase, so data is stable for CLK_DIV cycles before each rising edge.
REQ-020 The bit counter counts 0..CFG_WIDTH-1; after the high phase of bit CFG_WIDTH-1, the state becomes LATCH with Cfg_clk=0.
REQ-021 LATCH: Cfg_load=1 for exactly CLK_DIV cycles, with Cfg_out=0 and Cfg_clk=0.
REQ-022 After LATCH, the state becomes IDLE (or CHECK, see REQ-030), with a Done pulse in the last LATCH cycle.
REQ-023 Accept-to-Done latency is 1 + 2*CLK_DIV*CFG_WIDTH + CLK_DIV cycles without readback.
REQ-024 Busy=1 in every state except IDLE.
REQ-025 When Word_valid is held high, a new word is accepted in the cycle after Done; there are no back-to-back gaps beyond that one cycle.
REQ-026 Counter widths are $clog2(CFG_WIDTH) and $clog2(CLK_DIV+1); the divider wraps to 0 at CLK_DIV-1 without overflow.

Reset
REQ-027 Resetn=0 at any time, including mid-SHIFT or mid-LATCH, immediately forces the state to IDLE and the counters and shift register to 0.
REQ-028 Reset values: Cfg_out=0, Cfg_clk=0, Cfg_load=0, Busy=0, Done=0, Err=0, Word_ready=1.
REQ-029 A sequence aborted by reset is not resumed; the requester must resend the word.

Configuration
REQ-030 With SPC_CFG_READBACK_EN defined: after LATCH, the state becomes CHECK, which re-shifts the same word with identical timing, samples Cfg_ret on each Cfg_clk rising edge, and compares it with the word originally captured; Cfg_load stays 0 throughout CHECK.
REQ-031 With SPC_CFG_READBACK_EN defined: in CHECK, Err is set on any mismatch and holds until the next accept; Done is moved to the last CHECK cycle.
REQ-032 Without SPC_CFG_READBACK_EN: CHECK, the Cfg_ret logic and the Err register are not compiled; Err is tied to 0 and Cfg_ret is unused.

Structure
REQ-033 Shared package spc_cfg_pkg holds the state enum type and the default CFG_WIDTH and CLK_DIV constants.
REQ-034 Sub-module spc_cfg_clkdiv generates the Cfg_clk phase and the low-start and high-end strobes from CLK_DIV; the FSM and shift register stay in spc_cfg_sequencer.

Verification
REQ-035 CFG_WIDTH=8, CLK_DIV=2, Word=8'hA5 -> Cfg_out sampled on Cfg_clk rising edges reads 1,0,1,0,0,1,0,1; Cfg_load is high for 2 cycles; Done occurs 35 cycles after accept.
REQ-036 Word_valid held high with two words 8'h0F then 8'hF0 -> second accept occurs in the cycle after the first Done; Word_ready=0 throughout each sequence.
REQ-037 Resetn asserted after 3 bits of 8'hFF -> all outputs reach their reset values asynchronously; after release, Word_ready=1 and no Cfg_load pulse has occurred.
REQ-038 CLK_DIV=1, CFG_WIDTH=2 -> Cfg_clk toggles every cycle; latency is 6 cycles; no counter wraps incorrectly.
REQ-039 With SPC_CFG_READBACK_EN and a bench model of an 8-bit chain returning its contents -> Err=0; with one returned bit forced inverted -> Err=1 held until the next accept.
REQ-040 Without SPC_CFG_READBACK_EN, Cfg_ret toggled randomly -> Err stays 0 and Done timing matches REQ-023.
